credit_rx_buffer: RTL and testbench

Receiver end of the link-level credit flow-control scheme: an input flit buffer that accepts flits from an upstream sender, holds them until the local consumer reads them, and returns one credit pulse upstream per slot freed. `credit_o` drives the upstream credit counter's `incr_i`. The sender's `decr_i` fires on each flit it launches. This guarantees the sender never holds more credits than this buffer has free slots.

---
 rtl/credit_rx_buffer.sv | 102 ++++++++++
 tb/tb_credit_rx_buffer.sv | 153 +++++++++++++++
 2 files changed

// File: rtl/credit_rx_buffer.sv
// rtl/credit_rx_buffer.sv - receiver flit buffer returning one credit per freed slot
module credit_rx_buffer #(
  parameter int unsigned DATA_W = 32,
  parameter int unsigned DEPTH  = 4
) (
  input  logic                       clk_i,
  input  logic                       rst_n_i,
  input  logic                       flit_valid_i,
  input  logic [DATA_W-1:0]          flit_data_i,
  input  logic                       read_i,
  output logic [DATA_W-1:0]          flit_data_o,
  output logic                       empty_o,
  output logic [$clog2(DEPTH+1)-1:0] count_o,
  output logic                       credit_o,
  output logic                       overflow_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH+1);
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  typedef enum logic {IDLE, RET} state_t;

  logic [DATA_W-1:0] mem_q [DEPTH];
  logic [DATA_W-1:0] mem_d [DEPTH];
  logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0]  rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0]  count_q, count_d;
  logic              overflow_q, overflow_d;
  state_t            state_q, state_d;

  logic pop;
  logic push_ok;

  always_comb begin
    pop     = read_i && (count_q != '0);
    // a full buffer can still take a flit when a slot frees in the same cycle
    push_ok = flit_valid_i && ((count_q != FULL_CNT) || pop);

    mem_d      = mem_q;
    wr_ptr_d   = wr_ptr_q;
    rd_ptr_d   = rd_ptr_q;
    count_d    = count_q;
    overflow_d = overflow_q;

    if (push_ok) begin
      mem_d[wr_ptr_q] = flit_data_i;
      wr_ptr_d        = wr_ptr_q + PTR_W'(1);
    end
    if (flit_valid_i && !push_ok) begin
      overflow_d = 1'b1;
    end
    if (pop) begin
      rd_ptr_d = rd_ptr_q + PTR_W'(1);
    end
    if (push_ok && !pop) begin
      count_d = count_q + CNT_W'(1);
    end else if (pop && !push_ok) begin
      count_d = count_q - CNT_W'(1);
    end
  end

  always_comb begin
    state_d  = IDLE;
    credit_o = 1'b0;
    case (state_q)
      IDLE: credit_o = 1'b0;
      RET:  credit_o = 1'b1;
      default: credit_o = 1'b0;
    endcase
    if (pop) begin
      state_d = RET;
    end
  end

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_ptr_q   <= '0;
      rd_ptr_q   <= '0;
      count_q    <= '0;
      overflow_q <= 1'b0;
      state_q    <= IDLE;
    end else begin
      wr_ptr_q   <= wr_ptr_d;
      rd_ptr_q   <= rd_ptr_d;
      count_q    <= count_d;
      overflow_q <= overflow_d;
      state_q    <= state_d;
    end
  end

  // payload storage is not reset; contents are meaningless until written
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign flit_data_o = mem_q[rd_ptr_q];
  assign empty_o     = (count_q == '0);
  assign count_o     = count_q;
  assign overflow_o  = overflow_q;

endmodule

// File: tb/tb_credit_rx_buffer.sv
// tb/tb_credit_rx_buffer.sv - scoreboard bench for credit_rx_buffer
module tb_credit_rx_buffer;

  localparam int DATA_W = 32;
  localparam int DEPTH  = 4;

  logic              clk_i = 1'b0;
  logic              rst_n_i;
  logic              flit_valid_i;
  logic [DATA_W-1:0] flit_data_i;
  logic              read_i;
  logic [DATA_W-1:0] flit_data_o;
  logic              empty_o;
  logic [2:0]        count_o;
  logic              credit_o;
  logic              overflow_o;

  credit_rx_buffer #(.DATA_W(DATA_W), .DEPTH(DEPTH)) dut (
    .clk_i        (clk_i),
    .rst_n_i      (rst_n_i),
    .flit_valid_i (flit_valid_i),
    .flit_data_i  (flit_data_i),
    .read_i       (read_i),
    .flit_data_o  (flit_data_o),
    .empty_o      (empty_o),
    .count_o      (count_o),
    .credit_o     (credit_o),
    .overflow_o   (overflow_o)
  );

  always #5 clk_i = ~clk_i;

  logic [DATA_W-1:0] sb_q[$];
  int  m_count;
  bit  m_ovf;
  bit  m_credit;
  int  n_checks = 0;
  int  n_pass   = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, got, exp);
  endtask

  task automatic check_state();
    check("count", 32'(count_o), 32'(m_count));
    check("empty", 32'(empty_o), 32'(m_count == 0));
    check("credit", 32'(credit_o), 32'(m_credit));
    check("overflow", 32'(overflow_o), 32'(m_ovf));
    if (m_count != 0) check("head_peek", flit_data_o, sb_q[0]);
  endtask

  task automatic step(input bit v, input logic [DATA_W-1:0] d, input bit r);
    logic [DATA_W-1:0] exp;
    bit pop, acc;
    @(negedge clk_i);
    flit_valid_i = v;
    flit_data_i  = d;
    read_i       = r;
    #1;
    pop = r && (m_count != 0);
    acc = v && ((m_count < DEPTH) || pop);
    if (pop) begin
      exp = sb_q.pop_front();
      check("pop_data", flit_data_o, exp);
    end
    if (v && !acc) m_ovf = 1'b1;
    if (acc) sb_q.push_back(d);
    if (acc && !pop) m_count++;
    else if (pop && !acc) m_count--;
    m_credit = pop;
    @(posedge clk_i);
    #1;
    check_state();
  endtask

  task automatic model_reset();
    sb_q.delete();
    m_count  = 0;
    m_ovf    = 1'b0;
    m_credit = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n_i      = 1'b0;
    flit_valid_i = 1'b0;
    flit_data_i  = '0;
    read_i       = 1'b0;
    model_reset();
    #12;
    check_state();
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // fill
    for (int i = 0; i < 4; i++) step(1'b1, 32'hA0 + 32'(i), 1'b0);
    check("fill_head", flit_data_o, 32'hA0);
    // drain
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // overflow then simultaneous push/pop while full
    for (int i = 0; i < 4; i++) step(1'b1, 32'hB0 + 32'(i), 1'b0);
    step(1'b1, 32'hFF, 1'b0);
    step(1'b0, '0, 1'b0);
    step(1'b1, 32'hFE, 1'b1);
    for (int i = 0; i < 4; i++) step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // wrap-around at occupancy 1
    step(1'b1, 32'h0F, 1'b0);
    for (int i = 0; i < 10; i++) step(1'b1, 32'h10 + 32'(i), 1'b1);
    step(1'b0, '0, 1'b1);
    step(1'b0, '0, 1'b0);

    // empty boundary
    step(1'b0, '0, 1'b1);
    step(1'b1, 32'h55, 1'b1);

    // async reset with count 3 and a credit pending
    step(1'b1, 32'h56, 1'b0);
    step(1'b1, 32'h57, 1'b0);
    step(1'b1, 32'h58, 1'b1);
    #2;
    rst_n_i = 1'b0;
    #1;
    model_reset();
    check_state();
    @(negedge clk_i);
    flit_valid_i = 1'b0;
    read_i       = 1'b0;
    #1;
    check_state();
    @(negedge clk_i);
    rst_n_i = 1'b1;

    // random traffic
    for (int i = 0; i < 60; i++)
      step(1'($urandom_range(0, 1)), 32'($urandom), 1'($urandom_range(0, 1)));
    for (int i = 0; i < 5; i++) step(1'b0, '0, 1'b1);

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
